// File: rtl/muldiv_seq_if.sv
// Handshake and operand bus between the execute-stage control unit and the multi-cycle MUL/DIV sequencer.
// master drives requests and flush; slave returns status and the registered result.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             div_by_zero;

    modport master (
        output start, op, a, b, flush,
        input  ready, busy, done, result, div_by_zero
    );

    modport slave (
        input  start, op, a, b, flush,
        output ready, busy, done, result, div_by_zero
    );
endinterface

// File: rtl/muldiv_seq.sv
// Shift-add multiplier / restoring divider (MUL, UDIV, SDIV), one iteration per cycle.
// Latency WIDTH+3 cycles from accepted start to done; start is taken only in IDLE or DONE, flush aborts.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PREP  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_FIXUP = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] OP_UDIV = 2'b01;
    localparam logic [1:0] OP_SDIV = 2'b10;

    logic [2:0]       r_state;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_x;       // multiplier -> product low half, or dividend -> quotient
    logic [WIDTH-1:0] r_y;       // multiplicand, or divisor magnitude
    logic [WIDTH-1:0] r_acc;     // product high half, or partial remainder
    logic             r_neg;
    logic             r_bzero;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_result;
    logic             r_dz;

    logic             w_ready;
    logic             w_is_div;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_abs_x;
    logic [WIDTH-1:0] w_abs_y;

    assign w_ready  = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_is_div = (r_op == OP_UDIV) || (r_op == OP_SDIV);

    assign w_mul_sum = {1'b0, r_acc} + (r_x[0] ? {1'b0, r_y} : {(WIDTH+1){1'b0}});

    // Remainder shifted left needs WIDTH+1 bits so a 2^(WIDTH-1) magnitude never overflows.
    assign w_rem_sh = {r_acc, r_x[WIDTH-1]};
    assign w_ge     = w_rem_sh >= {1'b0, r_y};
    assign w_diff   = w_rem_sh[WIDTH-1:0] - r_y;

    assign w_abs_x = r_x[WIDTH-1] ? -r_x : r_x;
    assign w_abs_y = r_y[WIDTH-1] ? -r_y : r_y;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_op     <= 2'b00;
            r_x      <= '0;
            r_y      <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_bzero  <= 1'b0;
            r_count  <= '0;
            r_result <= '0;
            r_dz     <= 1'b0;
        end else if (bus.flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_op    <= bus.op;
                        r_x     <= bus.a;
                        r_y     <= bus.b;
                        r_state <= S_PREP;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_PREP: begin
                    if (r_op == OP_SDIV) begin
                        r_x <= w_abs_x;
                        r_y <= w_abs_y;
                    end
                    r_neg   <= (r_op == OP_SDIV) && (r_x[WIDTH-1] ^ r_y[WIDTH-1]);
                    r_bzero <= (r_y == '0);
                    r_acc   <= '0;
                    r_count <= '0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_is_div) begin
                        r_acc <= w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
                        r_x   <= {r_x[WIDTH-2:0], w_ge};
                    end else begin
                        r_acc <= w_mul_sum[WIDTH:1];
                        r_x   <= {w_mul_sum[0], r_x[WIDTH-1:1]};
                    end
                    r_count <= r_count + 1'b1;
                    if (r_count == CW'(WIDTH - 1)) begin
                        r_state <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    if (w_is_div && r_bzero) begin
                        r_result <= '0;
                        r_dz     <= 1'b1;
                    end else begin
                        r_result <= r_neg ? -r_x : r_x;
                        r_dz     <= 1'b0;
                    end
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ready       = w_ready;
    assign bus.busy        = (r_state == S_PREP) || (r_state == S_RUN) || (r_state == S_FIXUP);
    assign bus.done        = (r_state == S_DONE);
    assign bus.result      = r_result;
    assign bus.div_by_zero = r_dz;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench for muldiv_seq: arithmetic, latency, divide-by-zero, ignored start, back-to-back, reset and flush.
module tb_muldiv_seq;
    localparam int W = 32;
    localparam logic [1:0] MUL  = 2'b00;
    localparam logic [1:0] UDIV = 2'b01;
    localparam logic [1:0] SDIV = 2'b10;
    localparam logic [1:0] RSVD = 2'b11;

    logic clk;
    logic reset;
    int   nvec;
    int   nerr;

    muldiv_seq_if #(.WIDTH(W)) bus ();

    muldiv_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives a one-cycle start; called from a negedge so the next posedge samples it.
    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Edge index (1-based after the sampling edge) at which done is seen, or -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_res, input logic exp_dz);
        int lat;
        start_op(op, a, b);
        wait_done(lat);
        nvec++;
        if (lat != 35) begin
            nerr++;
            $display("FAIL %s latency: got %0d, expected 35", name, lat);
        end
        nvec++;
        if (bus.result !== exp_res || bus.div_by_zero !== exp_dz) begin
            nerr++;
            $display("FAIL %s result: got %h dz=%b, expected %h dz=%b",
                     name, bus.result, bus.div_by_zero, exp_res, exp_dz);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        nvec++;
        if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.result !== 32'h0 || bus.div_by_zero !== 1'b0) begin
            nerr++;
            $display("FAIL reset_state: ready=%b busy=%b done=%b result=%h dz=%b, expected 1 0 0 0 0",
                     bus.ready, bus.busy, bus.done, bus.result, bus.div_by_zero);
        end
    endtask

    task automatic test_udiv_basic;
        int lat;
        int busy_bad;
        busy_bad = 0;
        lat = -1;
        start_op(UDIV, 32'd100, 32'd7);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k <= 33 && bus.busy !== 1'b1) busy_bad++;
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
        nvec++;
        if (busy_bad != 0) begin
            nerr++;
            $display("FAIL udiv_busy: busy low on %0d of edges 1..33, expected 0", busy_bad);
        end
        nvec++;
        if (lat != 35) begin
            nerr++;
            $display("FAIL udiv_latency: done at edge %0d, expected 35", lat);
        end
        nvec++;
        if (bus.result !== 32'd14 || bus.div_by_zero !== 1'b0) begin
            nerr++;
            $display("FAIL udiv_100_7: got %h dz=%b, expected 0000000e dz=0", bus.result, bus.div_by_zero);
        end
        nvec++;
        @(negedge clk);
        if (bus.done !== 1'b0 || bus.ready !== 1'b1) begin
            nerr++;
            $display("FAIL done_pulse_width: done=%b ready=%b, expected 0 1", bus.done, bus.ready);
        end
        run_op("udiv_max_16", UDIV, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 1'b0);
    endtask

    task automatic test_sdiv;
        run_op("sdiv_m100_7",   SDIV, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 1'b0);
        run_op("sdiv_100_m7",   SDIV, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0);
        run_op("sdiv_m100_m7",  SDIV, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       1'b0);
        run_op("sdiv_min_m1",   SDIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
    endtask

    task automatic test_mul;
        run_op("mul_ffff_10001", MUL,  32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 1'b0);
        run_op("mul_m1_m1",      MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        run_op("mul_rsvd_5_6",   RSVD, 32'd5,        32'd6,        32'd30,       1'b0);
    endtask

    task automatic test_div_by_zero;
        run_op("udiv_5_0",   UDIV, 32'd5,   32'd0, 32'd0,  1'b1);
        run_op("sdiv_m9_0",  SDIV, 32'hFFFFFFF7, 32'd0, 32'd0, 1'b1);
        run_op("mul_after_dz", MUL, 32'd3, 32'd4, 32'd12, 1'b0);
    endtask

    task automatic test_back_to_back;
        int lat;
        lat = -1;
        start_op(MUL, 32'd6, 32'd7);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 10) begin
                bus.start = 1'b1;
                bus.a     = 32'd100;
                bus.b     = 32'd100;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
        nvec++;
        if (lat != 35 || bus.result !== 32'd42) begin
            nerr++;
            $display("FAIL ignored_start: done edge %0d result %h, expected 35 0000002a", lat, bus.result);
        end
        run_op("back_to_back_9_9", MUL, 32'd9, 32'd9, 32'd81, 1'b0);
    endtask

    task automatic test_reset_mid;
        start_op(UDIV, 32'd100, 32'd7);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        nvec++;
        if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.result !== 32'h0 || bus.div_by_zero !== 1'b0) begin
            nerr++;
            $display("FAIL reset_mid: ready=%b busy=%b done=%b result=%h dz=%b, expected 1 0 0 0 0",
                     bus.ready, bus.busy, bus.done, bus.result, bus.div_by_zero);
        end
    endtask

    task automatic test_flush;
        int seen;
        seen = 0;
        run_op("pre_flush_udiv", UDIV, 32'd100, 32'd7, 32'd14, 1'b0);
        start_op(UDIV, 32'd50, 32'd5);
        repeat (19) @(negedge clk);
        bus.flush = 1'b1;
        bus.start = 1'b1;
        bus.a     = 32'd8;
        bus.b     = 32'd2;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.start = 1'b0;
        nvec++;
        if (bus.busy !== 1'b0 || bus.ready !== 1'b1) begin
            nerr++;
            $display("FAIL flush_idle: busy=%b ready=%b, expected 0 1", bus.busy, bus.ready);
        end
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen++;
        end
        nvec++;
        if (seen != 0 || bus.result !== 32'd14 || bus.div_by_zero !== 1'b0) begin
            nerr++;
            $display("FAIL flush_no_done: done pulses %0d result %h dz=%b, expected 0 0000000e 0",
                     seen, bus.result, bus.div_by_zero);
        end
    endtask

    initial begin
        nvec      = 0;
        nerr      = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.flush = 1'b0;
        test_reset();
        test_udiv_basic();
        test_sdiv();
        test_mul();
        test_div_by_zero();
        test_back_to_back();
        test_reset_mid();
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
